score_event_arbiter: RTL and testbench
======================================

# score_event_arbiter

Sits between the collision detectors and the score counter. Collects one-cycle hit pulses from up to NUM_REQ requesters (bullet/enemy collision units) and buffers them in per-requester pending counters. It then feeds the score counter one `updateScore` pulse per main-FSM update-position window, choosing the requester round-robin. The score counter itself (saturating 8-bit, HEX display) is unchanged; this block only sequences its increment input.

## Interface
Parameters:
- `NUM_REQ`, 4: number of hit requesters (2..8).
- `PEND_W`, 3: pending counter width per requester; max pending = 2^PEND_W−1.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `hit_req`  in  NUM_REQ  one-cycle hit pulse per requester; multiple bits may be high at once.
- `inUpdatePositionStateMain`  in  1  main FSM update window; level, may last one or many cycles.
- `game_over`  in  1  synchronous flush of all pending hits.
- `score_in`  in  8  current score from the score counter.
- `updateScore`  out  1  increment strobe to the score counter.
- `grant`  out  NUM_REQ  one-hot; identifies the requester served this cycle, all-zero otherwise.
- `pending_any`  out  1  OR of all pending counters being non-zero.
- `overflow`  out  NUM_REQ  sticky per-requester flag: a hit was dropped.
- `high_score`  out  8  best score since reset (see Configuration).

## Operation
- **Pending counters:** `pend[i]` increments on `hit_req[i]` and decrements when `grant[i]` is asserted.
  - Simultaneous increment and decrement: no change.
  - At max with increment and no decrement: hold the value, drop the hit, set `overflow[i]`.
  - `overflow` clears only on reset.
- **FSM states:** IDLE, ISSUE, DONE.
  - IDLE → ISSUE when `inUpdatePositionStateMain` && `pending_any` && !`game_over`.
  - ISSUE → DONE when the strobe fires (window high). ISSUE → IDLE if the window has dropped; no strobe, nothing consumed.
  - DONE → IDLE when `inUpdatePositionStateMain` = 0. This gives at most one strobe per window.
- **Strobe and grant (combinational):**
  - `updateScore` = (state == ISSUE) && `inUpdatePositionStateMain` && !`game_over`.
  - `grant` = one-hot of the selected requester, qualified by `updateScore`.
- **Selection:** round-robin. Search starts at `rr_ptr` for the first `i` with `pend[i]` != 0. After a grant, `rr_ptr` ← (granted index + 1) mod NUM_REQ. `rr_ptr` resets to 0.
- **Saturated score:** when `score_in` = 255, grants still issue and still drain pending; the counter holds at 255.
- **game_over:** high for one or more cycles. Each cycle it clears all `pend` to 0, forces state to IDLE, and ignores `hit_req` that cycle. `rr_ptr` and `overflow` are kept.
- **Reset values:** state IDLE, `pend` 0, `rr_ptr` 0, `overflow` 0, `high_score` 0. Consequently `updateScore` = 0, `grant` = 0, `pending_any` = 0.
- **Mid-operation reset:** asynchronous; outputs go to reset values immediately.

## Timing
- A hit at cycle t is visible in `pend` and `pending_any` at t+1.
- If the window is high, the FSM is in ISSUE at t+2 and `updateScore`/`grant` are high during t+2. The score counter updates at the t+2→t+3 edge. Minimum hit-to-score latency is 3 edges.
- A window that is exactly 1 cycle long can never be served; windows must be ≥ 2 cycles. The main FSM's update state already meets this.
- `pending_any` and `overflow` are registered outputs.

## Configuration
- Macro: `SCORE_HIGHSCORE_EN`.
  - **Defined:** `high_score` ← `score_in` on any cycle where `score_in` > `high_score`. It survives `game_over` and clears only on `resetn`.
  - **Undefined:** no register is built, `high_score` is tied to 8'd0, and the port remains.

## Test plan
- **Single hit:** `hit_req`=4'b0001 at t, window high from t+1 for 3 cycles → `updateScore`=1 and `grant`=0001 only at t+2; `pend[0]` returns to 0.
- **Simultaneous hits:** `hit_req`=4'b1011 in one cycle, then four 3-cycle windows → grants 0001, 0010, 1000, none; exactly three strobes.
- **Overflow:** 9 pulses on `hit_req[2]` with no window → `pend[2]`=7, `overflow`=0100. Then 8 windows → exactly 7 strobes.
- **Window drop:** window high 1 cycle while pending → no strobe, `pend` unchanged. Next 3-cycle window → one strobe.
- **game_over flush:** `pend`={2,0,1,0}, then `game_over` for 1 cycle → `pending_any`=0 and no strobes in later windows. `high_score` unchanged: 37 if `score_in` peaked at 37, or 0 without the macro.

Source files
------------

// File: rtl/score_event_arbiter.sv
// Buffers per-requester hit pulses and issues at most one round-robin score strobe per update window.
// Optional high-score register is built when SCORE_HIGHSCORE_EN is defined.
module score_event_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PEND_W  = 3
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_REQ-1:0] hit_req,
   input  logic               inUpdatePositionStateMain,
   input  logic               game_over,
   input  logic [7:0]         score_in,
   output logic               updateScore,
   output logic [NUM_REQ-1:0] grant,
   output logic               pending_any,
   output logic [NUM_REQ-1:0] overflow,
   output logic [7:0]         high_score
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_e;

   state_e             state_q, state_d;
   logic [PEND_W-1:0]  pend_q [NUM_REQ];
   logic [PEND_W-1:0]  pend_d [NUM_REQ];
   logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
   logic [NUM_REQ-1:0] overflow_q, overflow_d;
   logic               pendingAny_q, pendingAny_d;
   logic [PTR_W-1:0]   selIdx;
   logic               selFound;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         rrPtr_q      <= '0;
         overflow_q   <= '0;
         pendingAny_q <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            pend_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rrPtr_q      <= rrPtr_d;
         overflow_q   <= overflow_d;
         pendingAny_q <= pendingAny_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            pend_q[i] <= pend_d[i];
         end
      end
   end

   // Round-robin search: first non-empty counter at or after rrPtr_q, wrapping.
   always_comb begin
      int idx;
      idx      = 0;
      selIdx   = '0;
      selFound = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rrPtr_q) + k) % NUM_REQ;
         if (!selFound && (pend_q[idx] != '0)) begin
            selFound = 1'b1;
            selIdx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      updateScore = (state_q == ISSUE) && inUpdatePositionStateMain && !game_over;
      case (state_q)
         IDLE: begin
            if (inUpdatePositionStateMain && pendingAny_q && !game_over) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = inUpdatePositionStateMain ? DONE : IDLE;
         end
         DONE: begin
            if (!inUpdatePositionStateMain) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (game_over) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      grant   = '0;
      rrPtr_d = rrPtr_q;
      if (updateScore && selFound) begin
         grant[selIdx] = 1'b1;
         rrPtr_d = (int'(selIdx) == NUM_REQ - 1) ? '0 : selIdx + PTR_W'(1);
      end
   end

   // A hit arriving on a full counter is dropped and latched into the sticky overflow flag.
   always_comb begin
      overflow_d   = overflow_q;
      pendingAny_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pend_d[i] = pend_q[i];
         if (game_over) begin
            pend_d[i] = '0;
         end else if (hit_req[i] && !grant[i]) begin
            if (pend_q[i] == PEND_MAX) begin
               overflow_d[i] = 1'b1;
            end else begin
               pend_d[i] = pend_q[i] + PEND_W'(1);
            end
         end else if (!hit_req[i] && grant[i]) begin
            pend_d[i] = pend_q[i] - PEND_W'(1);
         end
         if (pend_d[i] != '0) begin
            pendingAny_d = 1'b1;
         end
      end
   end

   assign pending_any = pendingAny_q;
   assign overflow    = overflow_q;

`ifdef SCORE_HIGHSCORE_EN
   logic [7:0] highScore_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         highScore_q <= 8'd0;
      end else if (score_in > highScore_q) begin
         highScore_q <= score_in;
      end
   end

   assign high_score = highScore_q;
`else
   logic unusedScoreIn;

   assign unusedScoreIn = ^score_in;
   assign high_score    = 8'd0;
`endif

endmodule

// File: tb/tb_score_event_arbiter.sv
// Scoreboard bench for score_event_arbiter: expected grants are queued by the stimulus,
// and a negedge monitor pops one entry for every strobe the arbiter presents.
module tb_score_event_arbiter;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic [3:0] hitReq = '0;
   logic       window = 1'b0;
   logic       gameOver = 1'b0;
   logic [7:0] score;
   logic       loadEn = 1'b0;
   logic [7:0] loadVal = '0;
   logic       updateScore;
   logic [3:0] grant;
   logic       pendingAny;
   logic [3:0] overflow;
   logic [7:0] highScore;

   logic [3:0] expQ [$];
   int         compared = 0;
   int         mismatched = 0;

   score_event_arbiter #(.NUM_REQ(4), .PEND_W(3)) dut (
      .clk                       (clk),
      .resetn                    (resetn),
      .hit_req                   (hitReq),
      .inUpdatePositionStateMain (window),
      .game_over                 (gameOver),
      .score_in                  (score),
      .updateScore               (updateScore),
      .grant                     (grant),
      .pending_any               (pendingAny),
      .overflow                  (overflow),
      .high_score                (highScore)
   );

   always #5 clk = ~clk;

   // Stand-in for the saturating score counter that consumes the strobe.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         score <= 8'd0;
      end else if (loadEn) begin
         score <= loadVal;
      end else if (updateScore && score != 8'd255) begin
         score <= score + 8'd1;
      end
   end

   // Every strobe must match the oldest queued grant.
   always @(negedge clk) begin
      if (resetn && updateScore) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_strobe: grant=%b, required no strobe", grant);
         end else begin
            logic [3:0] exp;
            exp = expQ.pop_front();
            if (grant !== exp) begin
               mismatched++;
               $display("[TB] FAIL grant: got %b, required %b", grant, exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] hit, input logic win, input logic go);
      hitReq   = hit;
      window   = win;
      gameOver = go;
      tick(1);
      hitReq   = '0;
      gameOver = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic applyReset();
      resetn   = 1'b0;
      hitReq   = '0;
      window   = 1'b0;
      gameOver = 1'b0;
      loadEn   = 1'b0;
      expQ.delete();
      tick(2);
      resetn = 1'b1;
      tick(1);
   endtask

   task automatic runWindow(input int len);
      window = 1'b1;
      tick(len);
      window = 1'b0;
      tick(2);
   endtask

   task automatic loadScore(input logic [7:0] v);
      loadVal = v;
      loadEn  = 1'b1;
      tick(1);
      loadEn  = 1'b0;
   endtask

   initial begin
      #1;
      applyReset();
      checkOutput("reset_updateScore", {7'd0, updateScore}, 8'd0);
      checkOutput("reset_grant", {4'd0, grant}, 8'd0);
      checkOutput("reset_pending_any", {7'd0, pendingAny}, 8'd0);
      checkOutput("reset_overflow", {4'd0, overflow}, 8'd0);
      checkOutput("reset_high_score", highScore, 8'd0);

      // Single hit, window opens the following cycle.
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput("single_pending", {7'd0, pendingAny}, 8'd1);
      expQ.push_back(4'b0001);
      runWindow(3);
      checkOutput("single_drained", {7'd0, pendingAny}, 8'd0);
      checkOutput("single_queue", 8'(expQ.size()), 8'd0);

      // Simultaneous hits served round-robin, one per window.
      applyReset();
      applyStimulus(4'b1011, 1'b0, 1'b0);
      expQ.push_back(4'b0001);
      expQ.push_back(4'b0010);
      expQ.push_back(4'b1000);
      for (int w = 0; w < 4; w++) begin
         runWindow(3);
      end
      checkOutput("simul_queue", 8'(expQ.size()), 8'd0);
      checkOutput("simul_pending", {7'd0, pendingAny}, 8'd0);

      // Nine pulses into a 3-bit counter: the ninth and eighth... only seven survive.
      applyReset();
      hitReq = 4'b0100;
      tick(9);
      hitReq = '0;
      checkOutput("ovf_flag", {4'd0, overflow}, 8'h04);
      for (int g = 0; g < 7; g++) begin
         expQ.push_back(4'b0100);
      end
      for (int w = 0; w < 8; w++) begin
         runWindow(3);
      end
      checkOutput("ovf_queue", 8'(expQ.size()), 8'd0);
      checkOutput("ovf_pending", {7'd0, pendingAny}, 8'd0);
      checkOutput("ovf_sticky", {4'd0, overflow}, 8'h04);

      // A one-cycle window is too short to be served.
      applyReset();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      window = 1'b0;
      tick(2);
      checkOutput("drop_pending", {7'd0, pendingAny}, 8'd1);
      expQ.push_back(4'b0001);
      runWindow(3);
      checkOutput("drop_queue", 8'(expQ.size()), 8'd0);
      checkOutput("drop_drained", {7'd0, pendingAny}, 8'd0);

      // game_over flushes pending hits, ignores a coincident hit, keeps the high score.
      applyReset();
      loadScore(8'd37);
      applyStimulus(4'b0101, 1'b0, 1'b0);
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput("go_pending_before", {7'd0, pendingAny}, 8'd1);
      applyStimulus(4'b0010, 1'b0, 1'b1);
      checkOutput("go_pending_after", {7'd0, pendingAny}, 8'd0);
      runWindow(3);
      runWindow(3);
      checkOutput("go_queue", 8'(expQ.size()), 8'd0);
      checkOutput("go_overflow", {4'd0, overflow}, 8'd0);
`ifdef SCORE_HIGHSCORE_EN
      checkOutput("go_high_score", highScore, 8'd37);
`else
      checkOutput("go_high_score", highScore, 8'd0);
`endif

      // Saturated score still drains pending hits.
      applyReset();
      loadScore(8'd255);
      applyStimulus(4'b0010, 1'b0, 1'b0);
      expQ.push_back(4'b0010);
      runWindow(3);
      checkOutput("sat_queue", 8'(expQ.size()), 8'd0);
      checkOutput("sat_pending", {7'd0, pendingAny}, 8'd0);
`ifdef SCORE_HIGHSCORE_EN
      checkOutput("sat_high_score", highScore, 8'd255);
`else
      checkOutput("sat_high_score", highScore, 8'd0);
`endif

      // Asynchronous reset while a strobe is being presented.
      applyReset();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("mid_strobe_before", {7'd0, updateScore}, 8'd1);
      resetn = 1'b0;
      #1;
      checkOutput("mid_updateScore", {7'd0, updateScore}, 8'd0);
      checkOutput("mid_grant", {4'd0, grant}, 8'd0);
      checkOutput("mid_pending", {7'd0, pendingAny}, 8'd0);
      checkOutput("mid_high_score", highScore, 8'd0);
      window = 1'b0;
      tick(2);
      resetn = 1'b1;
      tick(3);
      checkOutput("mid_post_pending", {7'd0, pendingAny}, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
